modulo_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative `Modulo` unit among `NUM_REQ` requesters in the TFHE key-generation datapath. Each requester presents signed 16.16 fixed-point operands (m, p). The block grants one requester at a time, launches the unit with a one-cycle start, and waits for its done. It returns the result to the originating requester with an ID tag, and screens out invalid moduli and hung operations.

---
 rtl/modulo_arbiter.sv | 158 +++++++++++++++
 tb/tb_modulo_arbiter.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_arbiter.sv
// modulo_arbiter: round-robin sharing of one iterative Modulo unit among
// NUM_REQ requesters, screening non-positive moduli and hung operations.
module modulo_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_m,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_p,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]               resp_id,
    output logic                          resp_err,
    output logic                          mod_start,
    output logic [DATA_WIDTH-1:0]         mod_m,
    output logic [DATA_WIDTH-1:0]         mod_p,
    input  logic [DATA_WIDTH-1:0]         mod_result,
    input  logic                          mod_ready,
    input  logic                          mod_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_WIDTH-1:0] m_q, m_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [ID_W:0]         cand;
    logic [ID_W-1:0]       win;
    logic                  found;
    logic                  accept;
    logic [DATA_WIDTH-1:0] m_sel;
    logic [DATA_WIDTH-1:0] p_sel;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

    assign accept = (state_q == IDLE) && mod_ready && found;
    assign m_sel  = req_m[win*DATA_WIDTH +: DATA_WIDTH];
    assign p_sel  = req_p[win*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ready = '0;
        if (rst && accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == RESP) begin
            resp_valid[id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        m_d     = m_q;
        p_d     = p_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    m_d  = m_sel;
                    p_d  = p_sel;
                    id_d = win;
                    rr_d = (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
                    // Non-positive modulus never reaches the unit
                    if (p_sel[DATA_WIDTH-1] || (p_sel == '0)) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mod_done) begin
                    data_d  = mod_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            m_q     <= '0;
            p_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            m_q     <= m_d;
            p_q     <= p_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mod_start = (state_q == ISSUE);
    assign mod_m     = m_q;
    assign mod_p     = p_q;
    assign resp_data = data_q;
    assign resp_id   = id_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_modulo_arbiter.sv
// Bench for modulo_arbiter: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_modulo_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [DW-1:0]   rm [N];
    logic [DW-1:0]   rp [N];
    logic [N*DW-1:0] req_m;
    logic [N*DW-1:0] req_p;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic [IW-1:0]   resp_id;
    logic            resp_err;
    logic            mod_start;
    logic [DW-1:0]   mod_m;
    logic [DW-1:0]   mod_p;
    logic [DW-1:0]   mod_result = '0;
    logic            mod_ready = 1'b1;
    logic            mod_done;
    logic            stub_done = 1'b0;
    logic            late_done = 1'b0;

    assign req_m    = {rm[3], rm[2], rm[1], rm[0]};
    assign req_p    = {rp[3], rp[2], rp[1], rp[0]};
    assign mod_done = stub_done | late_done;

    modulo_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (N),
        .ID_W      (IW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_m     (req_m),
        .req_p     (req_p),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_id   (resp_id),
        .resp_err  (resp_err),
        .mod_start (mod_start),
        .mod_m     (mod_m),
        .mod_p     (mod_p),
        .mod_result(mod_result),
        .mod_ready (mod_ready),
        .mod_done  (mod_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Floor modulo on raw 16.16 words equals the fixed-point remainder
    function automatic logic [DW-1:0] ref_mod(input logic [DW-1:0] m,
                                              input logic [DW-1:0] p);
        int r;
        r = $signed(m) % $signed(p);
        if (r < 0) r = r + $signed(p);
        return DW'(r);
    endfunction

    function automatic bit bad_p(input logic [DW-1:0] p);
        return $signed(p) <= 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Modulo unit stub: done lat cycles after the start is seen
    int            lat  = 1;
    bit            hang = 1'b0;
    bit            pend = 1'b0;
    int            cd   = 0;
    logic [DW-1:0] sm, sp;

    always @(negedge clk) begin
        stub_done <= 1'b0;
        if (!rst) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    pend <= 1'b0;
                    if (!hang) begin
                        stub_done  <= 1'b1;
                        mod_result <= ref_mod(sm, sp);
                    end
                end
            end
            if (mod_start) begin
                pend <= 1'b1;
                cd   <= lat;
                sm   <= mod_m;
                sp   <= mod_p;
            end
        end
    end

    // Event log of handshakes, starts and responses
    typedef struct {
        int cyc;
        int id;
    } acc_t;

    typedef struct {
        int            cyc;
        logic [N-1:0]  vec;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    acc_t  acc_q[$];
    int    start_q[$];
    resp_t resp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) acc_q.push_back('{cyc, i});
            end
            if (mod_start) start_q.push_back(cyc);
            if (resp_valid != '0) begin
                resp_q.push_back('{cyc, resp_valid, resp_id, resp_data,
                                   resp_err});
            end
        end
    end

    task automatic flush;
        acc_q.delete();
        start_q.delete();
        resp_q.delete();
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] m;
        logic [DW-1:0] p;
        int            lat;
        bit            hang;
        logic [DW-1:0] data;
        bit            err;
        int            rlat;
    } vec_t;

    vec_t tbl[9];

    task automatic run_vec(input int i);
        vec_t v;
        int   n;
        int   t;
        v = tbl[i];
        flush();
        lat  = v.lat;
        hang = v.hang;
        rm[v.id] = v.m;
        rp[v.id] = v.p;
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        n = 0;
        while (acc_q.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        req_valid = '0;
        chk($sformatf("vec%0d accepted", i), 64'(acc_q.size()), 64'd1);
        if (acc_q.size() == 0) return;
        t = acc_q[0].cyc;
        chk($sformatf("vec%0d grant id", i), 64'(acc_q[0].id), 64'(v.id));
        n = 0;
        while (resp_q.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("vec%0d responded", i), 64'(resp_q.size()), 64'd1);
        if (resp_q.size() == 0) return;
        chk($sformatf("vec%0d resp_valid", i), 64'(resp_q[0].vec),
            64'(1 << v.id));
        chk($sformatf("vec%0d resp_id", i), 64'(resp_q[0].id), 64'(v.id));
        chk($sformatf("vec%0d resp_data", i), 64'(resp_q[0].data),
            64'(v.data));
        chk($sformatf("vec%0d resp_err", i), 64'(resp_q[0].err), 64'(v.err));
        chk($sformatf("vec%0d latency", i), 64'(resp_q[0].cyc - t),
            64'(v.rlat));
        if (bad_p(v.p)) begin
            chk($sformatf("vec%0d no start", i), 64'(start_q.size()), 64'd0);
        end else begin
            chk($sformatf("vec%0d one start", i), 64'(start_q.size()), 64'd1);
            if (start_q.size() > 0) begin
                chk($sformatf("vec%0d start cycle", i),
                    64'(start_q[0] - t), 64'd1);
            end
        end
        tick();
        tick();
        chk($sformatf("vec%0d single resp", i), 64'(resp_q.size()), 64'd1);
    endtask

    task automatic wait_acc(input int want, input int lim);
        int n;
        n = 0;
        while (acc_q.size() < want && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_resp(input int want, input int lim);
        int n;
        n = 0;
        while (resp_q.size() < want && n < lim) begin
            tick();
            n++;
        end
    endtask

    // Random-phase reference model state
    int            ptr;
    bit            mb;
    int            mid, mt, mra;
    logic [DW-1:0] mm, mp, mdata;
    bit            mbad, merr;
    bit [N-1:0]    accf;

    initial begin
        tbl[0] = '{0, 32'h00090000, 32'h00040000, 1, 1'b0,
                   32'h00010000, 1'b0, 3};
        tbl[1] = '{1, 32'h00070000, 32'h00030000, 4, 1'b0,
                   32'h00010000, 1'b0, 6};
        tbl[2] = '{3, 32'hFFF90000, 32'h00030000, 2, 1'b0,
                   32'h00020000, 1'b0, 4};
        tbl[3] = '{2, 32'h00050000, 32'h00000000, 1, 1'b0,
                   32'h00000000, 1'b1, 1};
        tbl[4] = '{2, 32'h00050000, 32'hFFFC0000, 1, 1'b0,
                   32'h00000000, 1'b1, 1};
        tbl[5] = '{1, 32'h00080000, 32'h00000001, 3, 1'b0,
                   32'h00000000, 1'b0, 5};
        tbl[6] = '{0, 32'h7FFFFFFF, 32'h80000000, 1, 1'b0,
                   32'h00000000, 1'b1, 1};
        tbl[7] = '{2, 32'h00064000, 32'h00018000, 1, 1'b0,
                   32'h00004000, 1'b0, 3};
        tbl[8] = '{3, 32'h00090000, 32'h00040000, 1, 1'b1,
                   32'h00000000, 1'b1, TO + 3};

        // Reset state, with every requester already asking
        for (int i = 0; i < N; i++) begin
            rm[i] = DW'((i + 5) * 65536);
            rp[i] = 32'h00030000;
        end
        req_valid = '1;
        tick();
        tick();
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_data", 64'(resp_data), 64'd0);
        chk("reset resp_id", 64'(resp_id), 64'd0);
        chk("reset resp_err", 64'(resp_err), 64'd0);
        chk("reset mod_start", 64'(mod_start), 64'd0);
        chk("reset mod_m", 64'(mod_m), 64'd0);
        chk("reset mod_p", 64'(mod_p), 64'd0);

        // All four held valid from reset: grants rotate 0,1,2,3,0
        flush();
        lat = 1;
        rst = 1'b1;
        wait_resp(5, 80);
        req_valid = '0;
        tick();
        tick();
        chk("rr grant count", 64'(acc_q.size()), 64'd5);
        chk("rr resp count", 64'(resp_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < acc_q.size()) begin
                chk($sformatf("rr grant%0d", k), 64'(acc_q[k].id),
                    64'(k % N));
            end
            if (k < resp_q.size() && k < acc_q.size()) begin
                chk($sformatf("rr resp%0d id", k), 64'(resp_q[k].id),
                    64'(acc_q[k].id));
                chk($sformatf("rr resp%0d data", k), 64'(resp_q[k].data),
                    64'(ref_mod(rm[acc_q[k].id], rp[acc_q[k].id])));
            end
        end

        for (int i = 0; i < 9; i++) run_vec(i);

        // Late done after the timeout must be ignored
        flush();
        late_done = 1'b1;
        tick();
        late_done = 1'b0;
        tick();
        tick();
        tick();
        chk("late done no resp", 64'(resp_q.size()), 64'd0);
        chk("late done no start", 64'(start_q.size()), 64'd0);

        // Asynchronous reset while waiting on a hung unit
        flush();
        hang = 1'b1;
        rm[1] = 32'h00110000;
        rp[1] = 32'h00050000;
        req_valid[1] = 1'b1;
        wait_acc(1, 20);
        req_valid = '0;
        tick();
        tick();
        tick();
        chk("pre-reset mod_m", 64'(mod_m), 64'h00110000);
        req_valid[0] = 1'b1;
        rm[0] = 32'h000A0000;
        rp[0] = 32'h00030000;
        rst = 1'b0;
        #1;
        chk("async rst mod_m", 64'(mod_m), 64'd0);
        chk("async rst mod_p", 64'(mod_p), 64'd0);
        chk("async rst resp_id", 64'(resp_id), 64'd0);
        chk("async rst resp_err", 64'(resp_err), 64'd0);
        chk("async rst resp_valid", 64'(resp_valid), 64'd0);
        chk("async rst req_ready", 64'(req_ready), 64'd0);
        tick();
        tick();
        flush();
        hang = 1'b0;
        lat = 2;
        req_valid[3] = 1'b1;
        rst = 1'b1;
        wait_acc(1, 20);
        req_valid = '0;
        wait_resp(1, 30);
        tick();
        tick();
        chk("post-rst grant", 64'(acc_q.size() > 0 ? acc_q[0].id : -1), 64'd0);
        chk("post-rst resp count", 64'(resp_q.size()), 64'd1);
        if (resp_q.size() > 0) begin
            chk("post-rst resp id", 64'(resp_q[0].id), 64'd0);
            chk("post-rst resp data", 64'(resp_q[0].data), 64'h00010000);
            chk("post-rst resp err", 64'(resp_q[0].err), 64'd0);
        end

        // Unit busy holds off the grant; ready rises in the same cycle
        flush();
        lat = 1;
        mod_ready = 1'b0;
        rm[1] = 32'h000B0000;
        rp[1] = 32'h00040000;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("busy req_ready%0d", k), 64'(req_ready), 64'd0);
        end
        mod_ready = 1'b1;
        #1;
        chk("ready rise req_ready", 64'(req_ready), 64'b0010);
        wait_acc(1, 5);
        req_valid = '0;
        wait_resp(1, 20);
        chk("ready rise resp data",
            64'(resp_q.size() > 0 ? resp_q[0].data : '1), 64'h00030000);

        // Randomized traffic against the transaction-level model
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ptr = 0;
        mb = 1'b0;
        mra = -1;
        mt = 0;
        mid = 0;
        accf = '0;
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] er;
            int w;
            for (int i = 0; i < N; i++) begin
                if (accf[i]) begin
                    req_valid[i] = 1'b0;
                    accf[i] = 1'b0;
                end else if (c < 370 && !req_valid[i] &&
                             $urandom_range(0, 2) == 0) begin
                    rm[i] = $urandom;
                    rp[i] = ($urandom_range(0, 4) == 0) ?
                            32'($urandom_range(0, 3)) * 32'hFFFF0000 :
                            32'($urandom_range(1, 1000)) << 12;
                    req_valid[i] = 1'b1;
                end
            end
            mod_ready = ($urandom_range(0, 5) != 0);
            lat = $urandom_range(1, 4);
            @(negedge clk);
            #2;
            er = '0;
            w = -1;
            if (!mb && mod_ready) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
                end
            end
            if (w >= 0) er[w] = 1'b1;
            chk("rnd req_ready", 64'(req_ready), 64'(er));
            chk("rnd mod_start", 64'(mod_start),
                64'(mb && !mbad && cyc == mt + 1));
            chk("rnd resp_valid", 64'(resp_valid),
                64'((mb && cyc == mra) ? (1 << mid) : 0));
            if (mb && cyc == mra) begin
                chk("rnd resp_id", 64'(resp_id), 64'(mid));
                chk("rnd resp_data", 64'(resp_data), 64'(mdata));
                chk("rnd resp_err", 64'(resp_err), 64'(merr));
                mb = 1'b0;
            end else if (mb && !mbad && mra < 0 && cyc >= mt + 2 &&
                         mod_done) begin
                mra = cyc + 1;
                mdata = ref_mod(mm, mp);
                merr = 1'b0;
            end else if (mb && !mbad && mra < 0 && cyc == mt + 2 + TO) begin
                mra = cyc + 1;
                mdata = '0;
                merr = 1'b1;
            end
            if (w >= 0) begin
                mb = 1'b1;
                mid = w;
                mt = cyc;
                mm = rm[w];
                mp = rp[w];
                mbad = bad_p(mp);
                mra = mbad ? cyc + 1 : -1;
                mdata = '0;
                merr = mbad;
                ptr = (w + 1) % N;
                accf[w] = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
